// File: rtl/multi_nand.sv
// multi_nand: registered two-input NAND computed three independent ways
// (gate primitives, procedural block, continuous assign). The three results
// are captured together and cross-checked; disagreements are flagged and
// counted in a saturating counter. The inject input corrupts bit 0 of the
// dataflow path so the checker itself can be exercised.
module multi_nand #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inject,
  output logic [WIDTH-1:0] out_gate,
  output logic [WIDTH-1:0] out_beh,
  output logic [WIDTH-1:0] out_df,
  output logic             out_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] d;
  logic             disagree;

  logic [WIDTH-1:0] out_gate_q, out_gate_d;
  logic [WIDTH-1:0] out_beh_q,  out_beh_d;
  logic [WIDTH-1:0] out_df_q,   out_df_d;
  logic             out_valid_q, out_valid_d;
  logic             mismatch_q,  mismatch_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Gate-level path: one nand primitive per bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_nand
      nand u_nand (g[gi], a[gi], b[gi]);
    end
  endgenerate

  // Behavioural path: per-bit logical NAND in a procedural block.
  always @* begin
    h = '0;
    for (int i = 0; i < WIDTH; i++) begin
      h[i] = !(a[i] && b[i]);
    end
  end

  // Dataflow path, with the diagnostic flip applied to bit 0 only.
  assign d = ~(a & b) ^ WIDTH'(inject);

  assign disagree = (g != h) || (g != d);

  // Next-state: capture on in_valid, otherwise hold results and drop flags.
  always_comb begin
    out_gate_d  = out_gate_q;
    out_beh_d   = out_beh_q;
    out_df_d    = out_df_q;
    out_valid_d = 1'b0;
    mismatch_d  = 1'b0;
    err_count_d = err_count_q;
    if (in_valid) begin
      out_gate_d  = g;
      out_beh_d   = h;
      out_df_d    = d;
      out_valid_d = 1'b1;
      mismatch_d  = disagree;
      if (disagree && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset overriding everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_gate_q  <= '0;
      out_beh_q   <= '0;
      out_df_q    <= '0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_gate_q  <= out_gate_d;
      out_beh_q   <= out_beh_d;
      out_df_q    <= out_df_d;
      out_valid_q <= out_valid_d;
      mismatch_q  <= mismatch_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_gate  = out_gate_q;
  assign out_beh   = out_beh_q;
  assign out_df    = out_df_q;
  assign out_valid = out_valid_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_multi_nand.sv
// Testbench for multi_nand. Two instances share one stimulus stream:
// a 1-bit instance with a 2-bit counter and a 4-bit instance with an 8-bit
// counter. A behavioural model tracks both and every cycle is compared.
module tb_multi_nand;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a4, b4;
  logic       inject;

  logic       g1, h1, d1, v1, m1;
  logic [1:0] e1;
  logic [3:0] g4, h4, d4;
  logic       v4, m4;
  logic [7:0] e4;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = 1-bit instance, 1 = 4-bit instance.
  logic [3:0] m_gate [2];
  logic [3:0] m_beh  [2];
  logic [3:0] m_df   [2];
  logic       m_val  [2];
  logic       m_mis  [2];
  int         m_cnt  [2];

  always #5 clk = ~clk;

  multi_nand #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4[0]), .b(b4[0]),
    .inject(inject), .out_gate(g1), .out_beh(h1), .out_df(d1),
    .out_valid(v1), .mismatch(m1), .err_count(e1)
  );

  multi_nand #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .inject(inject), .out_gate(g4), .out_beh(h4), .out_df(d4),
    .out_valid(v4), .mismatch(m4), .err_count(e4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: NAND truth table applied per bit, bit 0 of dataflow flipped by
  // inject, any flip counts as a mismatch, counters saturate at 2^CNT_W-1.
  task automatic model_update(input bit r, input bit v, input logic [3:0] aa,
                              input logic [3:0] bb, input bit inj);
    for (int k = 0; k < 2; k++) begin
      logic [3:0] mask;
      int         cmax;
      mask = (k == 0) ? 4'h1 : 4'hF;
      cmax = (k == 0) ? 3 : 255;
      if (r) begin
        m_gate[k] = '0; m_beh[k] = '0; m_df[k] = '0;
        m_val[k] = 1'b0; m_mis[k] = 1'b0; m_cnt[k] = 0;
      end else if (v) begin
        m_gate[k] = ~(aa & bb) & mask;
        m_beh[k]  = m_gate[k];
        m_df[k]   = m_gate[k] ^ {3'b000, inj};
        m_val[k]  = 1'b1;
        m_mis[k]  = inj;
        if (inj && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
      end else begin
        m_val[k] = 1'b0;
        m_mis[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("w1_gate", 32'(g1), 32'(m_gate[0]));
    check("w1_beh",  32'(h1), 32'(m_beh[0]));
    check("w1_df",   32'(d1), 32'(m_df[0]));
    check("w1_valid", 32'(v1), 32'(m_val[0]));
    check("w1_mis",  32'(m1), 32'(m_mis[0]));
    check("w1_cnt",  32'(e1), 32'(m_cnt[0]));
    check("w4_gate", 32'(g4), 32'(m_gate[1]));
    check("w4_beh",  32'(h4), 32'(m_beh[1]));
    check("w4_df",   32'(d4), 32'(m_df[1]));
    check("w4_valid", 32'(v4), 32'(m_val[1]));
    check("w4_mis",  32'(m4), 32'(m_mis[1]));
    check("w4_cnt",  32'(e4), 32'(m_cnt[1]));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input bit r, input bit v, input logic [3:0] aa,
                      input logic [3:0] bb, input bit inj);
    rst = r; in_valid = v; a4 = aa; b4 = bb; inject = inj;
    @(posedge clk);
    model_update(r, v, aa, bb, inj);
    #1;
    check_all();
    $display("vec r=%0b v=%0b a=%h b=%h inj=%0b | w1 g/h/d=%0b%0b%0b cnt=%0d | w4 g=%h h=%h d=%h m=%0b cnt=%0d",
             r, v, aa, bb, inj, g1, h1, d1, e1, g4, h4, d4, m4, e4);
  endtask

  initial begin
    logic [3:0] tt_a, tt_b, tt_y;
    logic [2:0] sat_exp [5];
    rst = 1'b1; in_valid = 1'b0; a4 = '0; b4 = '0; inject = 1'b0;

    // Reset state, including rst overriding in_valid and inject.
    step(1, 1, 4'hF, 4'h0, 1);
    step(1, 0, 4'h0, 4'h0, 0);
    check("reset_cnt", 32'(e4), 32'd0);

    // Truth table on the 1-bit instance.
    tt_a = 4'b0011; tt_b = 4'b0101; tt_y = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      step(0, 1, {4{tt_a[3-k]}}, {4{tt_b[3-k]}}, 0);
      check("tt_gate", 32'(g1), 32'(tt_y[3-k]));
      check("tt_df", 32'(d1), 32'(tt_y[3-k]));
      check("tt_valid", 32'(v1), 32'd1);
    end

    // Hold: results stay while in_valid is low and inputs change.
    step(0, 1, 4'hF, 4'hF, 0);
    step(0, 0, 4'h0, 4'hF, 0);
    check("hold_gate", 32'(g4), 32'h0);
    check("hold_valid", 32'(v4), 32'd0);
    step(0, 0, 4'h0, 4'h0, 0);
    check("hold_beh", 32'(h4), 32'h0);

    // Reset mid-operation, then first capture after release.
    step(1, 1, 4'h0, 4'h0, 0);
    step(0, 1, 4'h0, 4'h0, 0);
    check("post_rst_gate", 32'(g4), 32'hF);

    // Fault injection and recovery.
    step(0, 1, 4'h0, 4'h0, 1);
    check("inj_df", 32'(d4), 32'hE);
    check("inj_mis", 32'(m4), 32'd1);
    check("inj_cnt", 32'(e4), 32'd1);
    step(0, 1, 4'h0, 4'h0, 0);
    check("inj_clr_mis", 32'(m4), 32'd0);
    check("inj_keep_cnt", 32'(e4), 32'd1);

    // Saturation of the 2-bit counter.
    step(1, 0, 4'h0, 4'h0, 0);
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 4'h3, 4'h5, 1);
      check("sat_cnt", 32'(e1), 32'(sat_exp[k]));
    end
    step(0, 0, 4'h0, 4'h0, 0);
    check("sat_idle_cnt", 32'(e1), 32'd3);

    // Vector width on the 4-bit instance.
    step(0, 1, 4'b1100, 4'b1010, 0);
    check("vec_gate", 32'(g4), 32'h7);
    check("vec_mis", 32'(m4), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(39) == 0), ($urandom_range(3) != 0),
           4'($urandom), 4'($urandom), ($urandom_range(5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_nand.md
Name: multi_nand

Overview:
- Registered two-input NAND block with three independent internal implementations of the same function:
  - gate-level: primitive nand instances, one per bit;
  - behavioural: procedural always block;
  - dataflow: continuous assign of ~(a & b).
- All three results are captured on the same clock edge.
- A cross-check compares them, flags any disagreement and counts disagreements.
- Used as a self-checking logic primitive and as a teaching/qualification block for synthesis and simulation flows.

Parameters:
- WIDTH, 1, bit width of operands a, b and of each result.
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b are valid this cycle; results are captured.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- inject  input  1  diagnostic; when high, bit 0 of the dataflow path is inverted before capture.
- out_gate  output  WIDTH  registered gate-level NAND result.
- out_beh  output  WIDTH  registered behavioural NAND result.
- out_df  output  WIDTH  registered dataflow NAND result.
- out_valid  output  1  registered copy of in_valid.
- mismatch  output  1  registered; the three results captured this cycle disagree.
- err_count  output  CNT_W  saturating count of captures with a mismatch.

Behaviour:
- Only the clock and reset described in Ports are used.
- Reset: on a rising clk edge with rst=1, the following are all cleared to 0, and rst overrides in_valid and inject:
  - out_gate, out_beh, out_df, out_valid, mismatch, err_count.
- Combinational core, per bit i:
  - gate path: g[i] = nand primitive(a[i], b[i]);
  - behavioural path: h[i] = !(a[i] && b[i]), computed in an always @* block;
  - dataflow path: d = ~(a & b), then d[0] is XORed with inject.
- Capture: on a rising edge with rst=0 and in_valid=1:
  - out_gate<=g, out_beh<=h, out_df<=d;
  - out_valid<=1;
  - mismatch<=(g!=h) || (g!=d).
- Latency: exactly one clock from in_valid to out_valid and results.
- Idle: on a rising edge with rst=0 and in_valid=0:
  - result registers hold their previous values;
  - out_valid<=0, mismatch<=0.
- err_count:
  - increments by 1 on every capture where the mismatch condition is true;
  - saturates at 2^CNT_W-1 and never wraps;
  - is not cleared by idle cycles.
- With inject=0, all three outputs are bit-identical on every capture and mismatch never asserts.
- Truth table per bit: 00->1, 01->1, 10->1, 11->0.
- Inputs are treated as 2-state. X propagation behaviour is not required to match across the three paths.
- No handshake back-pressure: every in_valid cycle is accepted.

Test Plan:
- Truth table, WIDTH=1, rst released, in_valid=1, inject=0:
  - apply (a,b) = 00, 01, 10, 11 on consecutive cycles;
  - one cycle later each time, out_gate = out_beh = out_df = 1, 1, 1, 0;
  - out_valid=1 and mismatch=0 on each;
  - err_count stays 0.
- Hold:
  - capture a=1, b=1 (outputs 0), then drop in_valid and change a=0;
  - outputs stay 0 and out_valid=0 until the next in_valid cycle.
- Reset mid-operation:
  - assert rst together with in_valid=1, a=0, b=0;
  - next cycle all outputs = 0, out_valid=0, err_count=0;
  - the first capture after release yields outputs 1.
- Fault injection:
  - in_valid=1, a=0, b=0, inject=1;
  - next cycle out_gate=1, out_beh=1, out_df=0, mismatch=1, err_count=1;
  - then with inject=0, mismatch=0 and err_count stays 1.
- Counter saturation, CNT_W=2:
  - 5 consecutive injected captures;
  - err_count reads 1, 2, 3, 3, 3.
- Vector width, WIDTH=4:
  - a=4'b1100, b=4'b1010, in_valid=1;
  - all three outputs = 4'b0111, mismatch=0.
